score_update_controller: RTL and testbench

- Sequences all score changes for the HUD score display.
- Collects one-cycle scoring event pulses from several game sources, queues them in per-source pending counters and grants them one at a time by fixed priority.
- Applies each granted event to a 4-digit BCD score with a digit-serial adder.
- Publishes frame-stable display digits to the score bitmap renderer, raises an extra-life pulse on thousands crossings and saturates at 9999.

---
 rtl/score_update_controller.sv | 260 ++++++++++++++++++++++++++
 tb/tb_score_update_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_update_controller.sv
// -----------------------------------------------------------------------------
// score_update_controller
//
// Purpose:
//   Sequences every change to the 4-digit BCD HUD score. One-cycle event
//   pulses from four game sources are queued in small per-source pending
//   counters. A fixed-priority arbiter (source 0 highest) grants one event at
//   a time. Each granted addend is applied to the score by a digit-serial BCD
//   adder (singles first), and the result is committed with saturation at
//   9999. The renderer sees a copy of the committed score that only changes on
//   startOfFrame, so digits never tear mid-frame.
//
// Ports:
//   clk               in   system clock
//   resetN            in   asynchronous active-low reset
//   startOfFrame      in   one-cycle pulse at frame start (display latch)
//   clear_score       in   synchronous new-game clear, overrides everything
//   player_eat_gold   in   event pulse, source 0 (highest priority)
//   player_eat_dimond in   event pulse, source 1
//   monster_killed    in   event pulse, source 2
//   bonus_collected   in   event pulse, source 3 (lowest priority)
//   disp_thousands    out  frame-stable BCD thousands digit
//   disp_hundreds     out  frame-stable BCD hundreds digit
//   disp_tens         out  frame-stable BCD tens digit
//   disp_singles      out  frame-stable BCD singles digit
//   busy              out  high while an event is being added/committed
//   extra_life_pulse  out  one-cycle pulse when a commit raises thousands
//   event_dropped     out  one-cycle pulse when an event hit a full counter
// -----------------------------------------------------------------------------
module score_update_controller #(
  parameter logic [15:0] GOLD_VAL    = 16'h0200,
  parameter logic [15:0] DIAMOND_VAL = 16'h0100,
  parameter logic [15:0] MONSTER_VAL = 16'h0250,
  parameter logic [15:0] BONUS_VAL   = 16'h1000,
  parameter int          PEND_W      = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       clear_score,
  input  logic       player_eat_gold,
  input  logic       player_eat_dimond,
  input  logic       monster_killed,
  input  logic       bonus_collected,
  output logic [3:0] disp_thousands,
  output logic [3:0] disp_hundreds,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_singles,
  output logic       busy,
  output logic       extra_life_pulse,
  output logic       event_dropped
);

  localparam int NSRC = 4;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADD    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Addend for a granted source.
  function automatic logic [15:0] src_value(input logic [1:0] src);
    logic [15:0] v;
    case (src)
      2'd0:    v = GOLD_VAL;
      2'd1:    v = DIAMOND_VAL;
      2'd2:    v = MONSTER_VAL;
      default: v = BONUS_VAL;
    endcase
    return v;
  endfunction

  // One BCD digit of the serial adder: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
    logic [4:0] s;
    logic [4:0] t;
    s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    t = s - 5'd10;
    if (s > 5'd9) return {1'b1, t[3:0]};
    else          return {1'b0, s[3:0]};
  endfunction

  // A carry out of the thousands digit means the true sum exceeds 9999.
  function automatic logic [15:0] sat_commit(input logic [15:0] sum,
                                             input logic        cout);
    return cout ? 16'h9999 : sum;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q,  state_d;
  logic [PEND_W-1:0]  pend_q [NSRC];
  logic [PEND_W-1:0]  pend_d [NSRC];
  logic [15:0]        score_q,  score_d;
  logic [15:0]        work_q,   work_d;
  logic [15:0]        addend_q, addend_d;
  logic [1:0]         dig_q,    dig_d;
  logic               carry_q,  carry_d;
  logic [15:0]        disp_q,   disp_d;
  logic               xlife_q,  xlife_d;
  logic               drop_q,   drop_d;

  logic [NSRC-1:0]    evt;
  logic [NSRC-1:0]    grant;
  logic [1:0]         gsel;
  logic               any_pend;
  logic [4:0]         dsum;
  logic [15:0]        commit_val;

  assign evt = {bonus_collected, monster_killed, player_eat_dimond, player_eat_gold};

  // ---------------------------------------------------------------------------
  // Fixed-priority arbiter: only the registered counters are looked at, so an
  // event pulsed this cycle becomes grantable next cycle at the earliest.
  // ---------------------------------------------------------------------------
  always_comb begin
    gsel     = 2'd0;
    any_pend = 1'b0;
    grant    = '0;
    // Scan from lowest priority upward so the lowest nonzero index wins.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend_q[i] != '0) begin
        gsel     = 2'(i);
        any_pend = 1'b1;
      end
    end
    if (state_q == S_IDLE && any_pend) grant[gsel] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Pending counters
  // ---------------------------------------------------------------------------
  always_comb begin
    drop_d = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      pend_d[i] = pend_q[i];
      if (clear_score) begin
        // New game: queued and simultaneous events are discarded silently.
        pend_d[i] = '0;
      end else begin
        case ({evt[i], grant[i]})
          2'b10: begin
            if (pend_q[i] == PEND_MAX) drop_d = 1'b1;
            else                       pend_d[i] = pend_q[i] + PEND_ONE;
          end
          2'b01:   pend_d[i] = pend_q[i] - PEND_ONE;
          default: pend_d[i] = pend_q[i];  // idle, or event and grant cancel
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE (grant) -> ADD x4 (singles..thousands) -> COMMIT
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    work_d     = work_q;
    addend_d   = addend_q;
    dig_d      = dig_q;
    carry_d    = carry_q;
    xlife_d    = 1'b0;
    dsum       = bcd_digit_add(work_q[4*dig_q +: 4], addend_q[4*dig_q +: 4], carry_q);
    commit_val = sat_commit(work_q, carry_q);

    if (clear_score) begin
      // Abort any in-flight add; nothing is committed.
      state_d  = S_IDLE;
      score_d  = '0;
      work_d   = '0;
      addend_d = '0;
      dig_d    = 2'd0;
      carry_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_pend) begin
            addend_d = src_value(gsel);
            work_d   = score_q;
            dig_d    = 2'd0;
            carry_d  = 1'b0;
            state_d  = S_ADD;
          end
        end
        S_ADD: begin
          work_d[4*dig_q +: 4] = dsum[3:0];
          carry_d              = dsum[4];
          dig_d                = dig_q + 2'd1;
          if (dig_q == 2'd3) state_d = S_COMMIT;
        end
        S_COMMIT: begin
          score_d = commit_val;
          // One pulse per commit, however many thousands were crossed.
          xlife_d = (commit_val[15:12] > score_q[15:12]);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Display copy only moves at frame start; a commit in the same cycle is
  // picked up at the following frame.
  always_comb begin
    disp_d = disp_q;
    if (startOfFrame) disp_d = score_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      work_q   <= '0;
      addend_q <= '0;
      dig_q    <= 2'd0;
      carry_q  <= 1'b0;
      disp_q   <= '0;
      xlife_q  <= 1'b0;
      drop_q   <= 1'b0;
      for (int i = 0; i < NSRC; i++) pend_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      work_q   <= work_d;
      addend_q <= addend_d;
      dig_q    <= dig_d;
      carry_q  <= carry_d;
      disp_q   <= disp_d;
      xlife_q  <= xlife_d;
      drop_q   <= drop_d;
      for (int i = 0; i < NSRC; i++) pend_q[i] <= pend_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy             = (state_q != S_IDLE);
  assign extra_life_pulse = xlife_q;
  assign event_dropped    = drop_q;
  assign disp_thousands   = disp_q[15:12];
  assign disp_hundreds    = disp_q[11:8];
  assign disp_tens        = disp_q[7:4];
  assign disp_singles     = disp_q[3:0];

endmodule

// File: tb/tb_score_update_controller.sv
// -----------------------------------------------------------------------------
// tb_score_update_controller
//
// Directed testbench for score_update_controller. Inputs change 1 time unit
// after the rising edge; outputs are sampled at the same point. "Cycle 0" of a
// scenario is the cycle in which the first event pulse is driven.
// -----------------------------------------------------------------------------
module tb_score_update_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetN;
  logic sof;
  logic clr;
  logic g;
  logic d;
  logic m;
  logic b;

  logic [3:0] th;
  logic [3:0] hu;
  logic [3:0] te;
  logic [3:0] si;
  logic       busy;
  logic       el;
  logic       drop;

  logic [15:0] disp_w;
  assign disp_w = {th, hu, te, si};

  score_update_controller dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (sof),
    .clear_score       (clr),
    .player_eat_gold   (g),
    .player_eat_dimond (d),
    .monster_killed    (m),
    .bonus_collected   (b),
    .disp_thousands    (th),
    .disp_hundreds     (hu),
    .disp_tens         (te),
    .disp_singles      (si),
    .busy              (busy),
    .extra_life_pulse  (el),
    .event_dropped     (drop)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int el_cnt   = 0;
  int drop_cnt = 0;
  int el0;
  int dr0;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (el)   el_cnt++;
    if (drop) drop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic do_reset();
    sof = 1'b0; clr = 1'b0;
    g = 1'b0; d = 1'b0; m = 1'b0; b = 1'b0;
    resetN = 1'b0;
    ticks(2);
    resetN = 1'b1;
    tick();
  endtask

  // Leaves the score at 0200 and shows it on the display.
  task automatic seed_0200();
    g = 1'b1; tick(); g = 1'b0;
    ticks(10);
    frame();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- Reset state ----------------
    do_reset();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_disp", {16'd0, disp_w}, 32'h0000);
    check("rst_el",   {31'd0, el},   32'd0);
    check("rst_drop", {31'd0, drop}, 32'd0);

    // ---------------- 1: single gold, latency, frame coincidence ----------------
    el0 = el_cnt;
    g = 1'b1; tick(); g = 1'b0;                 // cycle 1
    check("t1_busy_c1", {31'd0, busy}, 32'd0);
    tick();                                     // cycle 2
    for (int c = 2; c <= 6; c++) begin
      check($sformatf("t1_busy_c%0d", c), {31'd0, busy}, 32'd1);
      if (c == 6) sof = 1'b1;                   // frame start during COMMIT
      tick();
    end
    sof = 1'b0;                                 // cycle 7
    check("t1_busy_c7", {31'd0, busy}, 32'd0);
    check("t1_disp_precommit", {16'd0, disp_w}, 32'h0000);
    frame();
    check("t1_disp", {16'd0, disp_w}, 32'h0200);
    check("t1_el", el_cnt - el0, 0);

    // ---------------- 2: gold + diamond together ----------------
    do_reset();
    dr0 = drop_cnt;
    g = 1'b1; d = 1'b1; tick(); g = 1'b0; d = 1'b0;   // cycle 1
    ticks(6);                                         // cycle 7
    check("t2_busy_c7", {31'd0, busy}, 32'd0);
    tick();                                           // cycle 8
    check("t2_busy_c8", {31'd0, busy}, 32'd1);
    ticks(10);
    frame();
    check("t2_disp", {16'd0, disp_w}, 32'h0300);
    check("t2_drop", drop_cnt - dr0, 0);

    // ---------------- 3: carries through tens and hundreds ----------------
    do_reset();
    el0 = el_cnt;
    g = 1'b1; d = 1'b1; m = 1'b1; tick();
    d = 1'b0; m = 1'b0; ticks(2);
    g = 1'b0;
    ticks(40);
    frame();
    check("t3_disp_0950", {16'd0, disp_w}, 32'h0950);
    check("t3_el_pre", el_cnt - el0, 0);
    el0 = el_cnt;
    m = 1'b1; tick(); m = 1'b0;
    ticks(10);
    frame();
    check("t3_disp_1200", {16'd0, disp_w}, 32'h1200);
    check("t3_el", el_cnt - el0, 1);

    // ---------------- 4: saturation at 9999 ----------------
    do_reset();
    el0 = el_cnt; dr0 = drop_cnt;
    g = 1'b1; d = 1'b1; b = 1'b1; tick();
    d = 1'b0; ticks(3);
    g = 1'b0; ticks(2);
    b = 1'b0; ticks(80);
    b = 1'b1; ticks(3);
    b = 1'b0; ticks(25);
    frame();
    check("t4_disp_9900", {16'd0, disp_w}, 32'h9900);
    check("t4_el_9", el_cnt - el0, 9);
    check("t4_drop", drop_cnt - dr0, 0);
    el0 = el_cnt;
    b = 1'b1; tick(); b = 1'b0;
    ticks(10);
    frame();
    check("t4_disp_sat", {16'd0, disp_w}, 32'h9999);
    check("t4_el_sat", el_cnt - el0, 0);
    g = 1'b1; tick(); g = 1'b0;
    ticks(10);
    frame();
    check("t4_disp_hold", {16'd0, disp_w}, 32'h9999);

    // ---------------- 5: pending counter saturation ----------------
    // Bonus in cycle 0, gold in cycles 1..9. The first gold grant happens in
    // cycle 7, so the counter reaches 7 at cycle 9 and the cycle-9 gold drops.
    do_reset();
    el0 = el_cnt; dr0 = drop_cnt;
    b = 1'b1; tick(); b = 1'b0;
    g = 1'b1; ticks(8);                          // cycle 9
    check("t5_drop_c9", {31'd0, drop}, 32'd0);
    tick(); g = 1'b0;                            // cycle 10
    check("t5_drop_c10", {31'd0, drop}, 32'd1);
    tick();                                      // cycle 11
    check("t5_drop_c11", {31'd0, drop}, 32'd0);
    ticks(60);
    frame();
    check("t5_disp", {16'd0, disp_w}, 32'h2600);
    check("t5_drop_cnt", drop_cnt - dr0, 1);
    check("t5_el", el_cnt - el0, 2);

    // ---------------- 6a: clear_score mid-ADD ----------------
    do_reset();
    seed_0200();
    check("t6_disp_seed", {16'd0, disp_w}, 32'h0200);
    el0 = el_cnt;
    g = 1'b1; ticks(3);                          // golds in cycles 0..2
    g = 1'b0; tick();                            // cycle 4: ADD digit 2
    check("t6_busy_c4", {31'd0, busy}, 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;              // cycle 5
    check("t6_busy_c5", {31'd0, busy}, 32'd0);
    check("t6_disp_stable", {16'd0, disp_w}, 32'h0200);
    ticks(20);
    check("t6_busy_late", {31'd0, busy}, 32'd0);
    frame();
    check("t6_disp_clr", {16'd0, disp_w}, 32'h0000);
    check("t6_el", el_cnt - el0, 0);

    // ---------------- 6b: async reset mid-ADD ----------------
    do_reset();
    seed_0200();
    check("t6b_disp_seed", {16'd0, disp_w}, 32'h0200);
    el0 = el_cnt;
    g = 1'b1; ticks(3);
    g = 1'b0; tick();                            // cycle 4: ADD digit 2
    resetN = 1'b0;
    #1;
    check("t6b_busy_rst", {31'd0, busy}, 32'd0);
    check("t6b_disp_rst", {16'd0, disp_w}, 32'h0000);
    tick();
    resetN = 1'b1;
    ticks(20);
    check("t6b_busy_late", {31'd0, busy}, 32'd0);
    frame();
    check("t6b_disp", {16'd0, disp_w}, 32'h0000);
    check("t6b_el", el_cnt - el0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
